// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute/memory stage and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: decodes and checks one access at a time, drives the
// data-memory port and returns a single-cycle response.
module load_store_unit #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  load_store_unit_if.slave      bus,
  output logic                  mem_en_write,
  output logic                  mem_en_read,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_din,
  output logic [1:0]            mem_size,
  output logic                  mem_unsigned,
  input  logic [WORD_SIZE-1:0]  mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT, RESP} state_t;

  state_t                 state_reg;
  logic                   is_write_reg;
  logic                   mem_en_write_reg;
  logic                   mem_en_read_reg;
  logic [ADDR_SIZE-1:0]   mem_addr_reg;
  logic [WORD_SIZE-1:0]   mem_din_reg;
  logic [1:0]             mem_size_reg;
  logic                   mem_unsigned_reg;
  logic                   resp_valid_reg;
  logic [1:0]             resp_err_reg;
  logic [31:0]            resp_rdata_reg;

  logic                   legal_next;
  logic                   misaligned_next;
  logic                   out_of_range_next;
  logic [1:0]             size_next;
  logic                   unsigned_next;
  logic [1:0]             err_next;
  logic [WORD_SIZE-1:0]   din_next;

  always_comb begin
    size_next     = bus.req_funct3[1:0];
    unsigned_next = bus.req_funct3[2];
    if (bus.req_write) begin
      legal_next = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
    end else begin
      legal_next = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                   (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                   (bus.req_funct3 == 3'b101);
    end
    misaligned_next   = ((size_next == 2'b01) && bus.req_addr[0]) ||
                        ((size_next == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range_next = |bus.req_addr[31:ADDR_SIZE];
    if (!legal_next)             err_next = 2'b11;
    else if (misaligned_next)    err_next = 2'b01;
    else if (out_of_range_next)  err_next = 2'b10;
    else                         err_next = 2'b00;
  end

  // Replicating the narrow store data onto every lane lets the memory pick
  // whichever lane the byte offset selects without any shifting here.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_SIZE / 8; gi++) begin : g_lane
      assign din_next[8*gi +: 8] =
          (size_next == 2'b00) ? bus.req_wdata[7:0] :
          (size_next == 2'b01) ? bus.req_wdata[8*(gi % 2) +: 8] :
                                 bus.req_wdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      is_write_reg     <= 1'b0;
      mem_en_write_reg <= 1'b0;
      mem_en_read_reg  <= 1'b0;
      mem_addr_reg     <= '0;
      mem_din_reg      <= '0;
      mem_size_reg     <= 2'b00;
      mem_unsigned_reg <= 1'b0;
      resp_valid_reg   <= 1'b0;
      resp_err_reg     <= 2'b00;
      resp_rdata_reg   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_valid_reg <= 1'b0;
          if (bus.req_valid) begin
            if (err_next != 2'b00) begin
              // Rejected accesses never touch memory.
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= err_next;
              resp_rdata_reg <= 32'h0;
            end else begin
              state_reg        <= ACCESS;
              is_write_reg     <= bus.req_write;
              mem_en_write_reg <= bus.req_write;
              mem_en_read_reg  <= !bus.req_write;
              mem_addr_reg     <= bus.req_addr[ADDR_SIZE-1:0];
              mem_din_reg      <= din_next;
              mem_size_reg     <= size_next;
              mem_unsigned_reg <= unsigned_next;
            end
          end
        end
        ACCESS: begin
          mem_en_write_reg <= 1'b0;
          mem_en_read_reg  <= 1'b0;
          if (is_write_reg) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 2'b00;
            resp_rdata_reg <= 32'h0;
          end else begin
            state_reg <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 2'b00;
          resp_rdata_reg <= mem_dout[31:0];
        end
        RESP: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign mem_en_write   = mem_en_write_reg;
  assign mem_en_read    = mem_en_read_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_din        = mem_din_reg;
  assign mem_size       = mem_size_reg;
  assign mem_unsigned   = mem_unsigned_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-addressed data memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        mem_en_write;
  logic        mem_en_read;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_dout;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_SIZE(10), .WORD_SIZE(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .mem_en_write (mem_en_write),
    .mem_en_read  (mem_en_read),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: reset preloads word 0x010 = 0x8000_00F0; read data appears
  // the cycle after the read-enable cycle.
  logic [7:0] mem [0:1023];

  function automatic logic [31:0] rd_ext(input logic [9:0] a, input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[a];
    h = {mem[a + 10'd1], mem[a]};
    case (sz)
      2'b00:   rd_ext = u ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   rd_ext = u ? {16'h0, h} : {{16{h[15]}}, h};
      default: rd_ext = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hF0;
      mem[19] <= 8'h80;
      mem_dout <= 32'h0;
    end else begin
      if (mem_en_read) mem_dout <= rd_ext(mem_addr, mem_size, mem_unsigned);
      if (mem_en_write) begin
        case (mem_size)
          2'b00: mem[mem_addr] <= mem_din[8*mem_addr[1:0] +: 8];
          2'b01: begin
            mem[mem_addr]         <= mem_din[8*mem_addr[1:0] +: 8];
            mem[mem_addr + 10'd1] <= mem_din[8*(mem_addr[1:0] + 2'd1) +: 8];
          end
          default: begin
            for (int i = 0; i < 4; i++) mem[mem_addr + 10'(i)] <= mem_din[8*i +: 8];
          end
        endcase
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          t_resp_cyc, t_en_cyc, t_en_cnt;
  logic [31:0] t_din, t_rdata;
  logic [1:0]  t_size, t_err;

  task automatic txn(input string name, input logic w, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
    bus.req_funct3 = f3; bus.req_wdata = wd;
    @(posedge clk);
    t_resp_cyc = 0; t_en_cyc = 0; t_en_cnt = 0;
    t_din = 32'h0; t_size = 2'b11; t_rdata = 32'hDEAD_BEEF; t_err = 2'bxx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble the request to show mid-transaction changes are ignored.
        bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFFF;
        bus.req_funct3 = 3'b111; bus.req_wdata = ~wd;
      end
      if (mem_en_read || mem_en_write) begin
        t_en_cnt++; t_en_cyc = k; t_din = mem_din; t_size = mem_size;
      end
      if (bus.resp_valid) begin
        t_resp_cyc = k; t_err = bus.resp_err; t_rdata = bus.resp_rdata;
        break;
      end
    end
    $display("txn %-10s w=%0d addr=0x%08h f3=%03b -> resp_cyc=%0d err=%02b rdata=0x%08h",
             name, w, a, f3, t_resp_cyc, t_err, t_rdata);
  endtask

  task automatic chk_load(input string name, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] exp);
    txn(name, 1'b0, a, f3, 32'h0);
    check_val({name, " resp_cyc"}, 32'(t_resp_cyc), 32'd3);
    check_val({name, " en_cyc"},   32'(t_en_cyc),   32'd1);
    check_val({name, " en_cnt"},   32'(t_en_cnt),   32'd1);
    check_val({name, " err"},      32'(t_err),      32'd0);
    check_val({name, " rdata"},    t_rdata,         exp);
  endtask

  task automatic chk_store(input string name, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] wd, input logic [31:0] exp_din, input logic [1:0] exp_sz);
    txn(name, 1'b1, a, f3, wd);
    check_val({name, " resp_cyc"}, 32'(t_resp_cyc), 32'd2);
    check_val({name, " en_cyc"},   32'(t_en_cyc),   32'd1);
    check_val({name, " en_cnt"},   32'(t_en_cnt),   32'd1);
    check_val({name, " din"},      t_din,           exp_din);
    check_val({name, " size"},     32'(t_size),     32'(exp_sz));
    check_val({name, " err"},      32'(t_err),      32'd0);
    check_val({name, " rdata"},    t_rdata,         32'h0);
  endtask

  task automatic chk_error(input string name, input logic w, input logic [31:0] a,
                           input logic [2:0] f3, input logic [1:0] exp_err);
    txn(name, w, a, f3, 32'h5555_AAAA);
    check_val({name, " resp_cyc"}, 32'(t_resp_cyc), 32'd1);
    check_val({name, " en_cnt"},   32'(t_en_cnt),   32'd0);
    check_val({name, " err"},      32'(t_err),      32'(exp_err));
    check_val({name, " rdata"},    t_rdata,         32'h0);
  endtask

  initial begin
    logic [7:0]  rdy;
    int          r1_cyc, r2_cyc, w_cyc, nresp;
    logic [31:0] r1_data, r2_data;
    logic [1:0]  r1_err, r2_err;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    bus.req_funct3 = 3'b000; bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset ready",      32'(bus.req_ready),  32'd1);
    check_val("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("reset en",         32'({mem_en_write, mem_en_read}), 32'd0);
    check_val("reset mem_addr",   32'(mem_addr), 32'd0);
    rst = 1'b0;

    chk_load("LW 010",  32'h010, 3'b010, 32'h8000_00F0);
    chk_load("LB 010",  32'h010, 3'b000, 32'hFFFF_FFF0);
    chk_load("LBU 010", 32'h010, 3'b100, 32'h0000_00F0);
    chk_load("LH 012",  32'h012, 3'b001, 32'hFFFF_8000);
    chk_load("LHU 012", 32'h012, 3'b101, 32'h0000_8000);

    chk_error("LH 011",   1'b0, 32'h011, 3'b001, 2'b01);
    chk_error("SW 400",   1'b1, 32'h400, 3'b010, 2'b10);
    chk_error("LD f3=011",1'b0, 32'h010, 3'b011, 2'b11);
    chk_error("LW 401",   1'b0, 32'h401, 3'b010, 2'b01);
    chk_error("ST f3=100",1'b1, 32'h010, 3'b100, 2'b11);

    chk_store("SB 013", 32'h013, 3'b000, 32'h0000_00AB, 32'hABAB_ABAB, 2'b00);
    chk_load("LW 010b", 32'h010, 3'b010, 32'hAB00_00F0);
    chk_store("SH 016", 32'h016, 3'b001, 32'h1234_5678, 32'h5678_5678, 2'b01);
    chk_load("LW 014",  32'h014, 3'b010, 32'h5678_0000);

    // Back-to-back: valid held high, LW 0x010 then SW 0x018.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h010;
    bus.req_funct3 = 3'b010; bus.req_wdata = 32'h0;
    @(posedge clk);
    rdy = 8'h0; r1_cyc = 0; r2_cyc = 0; w_cyc = 0; nresp = 0;
    r1_data = 32'h0; r2_data = 32'hDEAD_BEEF; r1_err = 2'bxx; r2_err = 2'bxx;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_write = 1'b1; bus.req_addr = 32'h018; bus.req_wdata = 32'hCAFE_F00D;
      end
      rdy[k] = bus.req_ready;
      if (mem_en_write) begin w_cyc = k; bus.req_valid = 1'b0; end
      if (bus.resp_valid) begin
        nresp++;
        if (nresp == 1) begin r1_cyc = k; r1_data = bus.resp_rdata; r1_err = bus.resp_err; end
        else begin r2_cyc = k; r2_data = bus.resp_rdata; r2_err = bus.resp_err; end
      end
      if (nresp == 2) break;
    end
    bus.req_valid = 1'b0;
    $display("txn b2b        ready=%08b resp1_cyc=%0d rdata=0x%08h wr_cyc=%0d resp2_cyc=%0d",
             rdy, r1_cyc, r1_data, w_cyc, r2_cyc);
    check_val("b2b ready 1..4", 32'(rdy[4:1]), 32'b1000);
    check_val("b2b resp1 cyc",  32'(r1_cyc),   32'd3);
    check_val("b2b resp1 data", r1_data,       32'hAB00_00F0);
    check_val("b2b resp1 err",  32'(r1_err),   32'd0);
    check_val("b2b wr cyc",     32'(w_cyc),    32'd5);
    check_val("b2b resp2 cyc",  32'(r2_cyc),   32'd6);
    check_val("b2b resp2 data", r2_data,       32'h0);
    check_val("b2b resp2 err",  32'(r2_err),   32'd0);
    chk_load("LW 018", 32'h018, 3'b010, 32'hCAFE_F00D);

    // Reset while a load sits in LOAD_WAIT.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h014;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst ready",      32'(bus.req_ready),  32'd1);
    check_val("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst rdata",      bus.resp_rdata,      32'h0);
    check_val("rst en",         32'({mem_en_write, mem_en_read}), 32'd0);
    check_val("rst mem_din",    mem_din,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    nresp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    $display("txn rst-in-LW  stray_resp=%0d", nresp);
    check_val("rst no resp", 32'(nresp), 32'd0);
    chk_load("LW after rst", 32'h010, 3'b010, 32'h8000_00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
